// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: run controller for the 3-bit up-counter datapath.
// A start command runs the count from 0 up to a latched limit, repeats that
// for a latched number of extra passes, then pulses done. Runs can be paused
// (level-sensitive) or aborted with stop.
// Optional build macro: COUNT_SEQ_GRAY_EN -- when defined, q presents the Gray
// code of the internal binary count; limit compare and wrap stay binary.
module count_seq_ctrl #(
  parameter int WIDTH  = 3,
  parameter int PASS_W = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [WIDTH-1:0]  limit,
  input  logic [PASS_W-1:0] passes,
  output logic [WIDTH-1:0]  q,
  output logic [PASS_W-1:0] pass_cnt,
  output logic              busy,
  output logic              wrap,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [WIDTH-1:0]    limit_q, limit_d;
  logic [PASS_W-1:0]   passes_q, passes_d;
  logic                wrap_q, wrap_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state logic: stop beats pause, pause beats counting; limit/passes
  // are only sampled when a start is accepted in IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    limit_d  = limit_q;
    passes_d = passes_q;
    wrap_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        pass_d = '0;
        if (start) begin
          limit_d  = limit;
          passes_d = passes;
          state_d  = RUN;
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
          pass_d  = '0;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (cnt_q != limit_q) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else begin
          cnt_d  = '0;
          wrap_d = 1'b1;
          if (pass_q == passes_q) begin
            state_d = DONE;
          end else begin
            pass_d = pass_q + PASS_W'(1);
          end
        end
      end

      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
          pass_d  = '0;
        end else if (!pause) begin
          // Resume edge does not count; counting restarts on the edge after.
          state_d = RUN;
        end
      end

      DONE: begin
        // pass_cnt shows its final value during DONE and clears on leaving.
        cnt_d   = '0;
        pass_d  = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pass_d  = '0;
      end
    endcase
  end

  // Status flags are derived from the next state so they are registered
  // alongside the state itself.
  always_comb begin
    busy_d = (state_d == RUN) || (state_d == PAUSE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; clr clears everything immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pass_q   <= '0;
      limit_q  <= '0;
      passes_q <= '0;
      wrap_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      limit_q  <= limit_d;
      passes_q <= passes_d;
      wrap_q   <= wrap_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef COUNT_SEQ_GRAY_EN
  logic [WIDTH-1:0] gray_q, gray_d;

  // Gray encoding is taken from the next binary count so q carries no extra
  // latency relative to the binary register.
  always_comb begin
    gray_d = cnt_d ^ (cnt_d >> 1);
  end

  // Registered Gray-coded output.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      gray_q <= '0;
    end else begin
      gray_q <= gray_d;
    end
  end

  assign q = gray_q;
`else
  assign q = cnt_q;
`endif

  assign pass_cnt = pass_q;
  assign busy     = busy_q;
  assign wrap     = wrap_q;
  assign done     = done_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed testbench for count_seq_ctrl. Expected values are hand-derived
// from the cycle-level behaviour of the run controller.
module tb_count_seq_ctrl;

  logic       clk;
  logic       clr;
  logic       start;
  logic       stop;
  logic       pause;
  logic [2:0] limit;
  logic [1:0] passes;
  logic [2:0] q;
  logic [1:0] pass_cnt;
  logic       busy;
  logic       wrap;
  logic       done;

  int checks;
  int failures;

  count_seq_ctrl #(.WIDTH(3), .PASS_W(2)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .limit    (limit),
    .passes   (passes),
    .q        (q),
    .pass_cnt (pass_cnt),
    .busy     (busy),
    .wrap     (wrap),
    .done     (done)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something goes badly wrong.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Expected presentation of a binary count on q.
  function automatic logic [2:0] to_q(input logic [2:0] b);
`ifdef COUNT_SEQ_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge with the given run parameters.
  task automatic start_run(input logic [2:0] lim, input logic [1:0] pas);
    limit  = lim;
    passes = pas;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    limit = 3'd0; passes = 2'd0;
    tick(); tick();
    checks++;
    if ({q, pass_cnt, busy, wrap, done} !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%b exp=%b", {q, pass_cnt, busy, wrap, done}, 8'd0);
    end
    clr = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || q !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_idle busy=%b q=%0d exp busy=0 q=0", busy, q);
    end
  endtask

  task automatic test_basic_run();
    int nwrap;
    int ndone;
    logic [2:0] eq;
    logic [1:0] ep;
    nwrap = 0; ndone = 0;
    start_run(3'd4, 2'd1);
    checks++;
    if (busy !== 1'b1 || q !== to_q(3'd0)) begin
      failures++;
      $display("[TB] FAIL basic_start busy=%b q=%0d exp busy=1 q=%0d", busy, q, to_q(3'd0));
    end
    for (int i = 1; i <= 10; i++) begin
      tick();
      eq = 3'(i % 5);
      ep = (i < 5) ? 2'd0 : 2'd1;
      if (wrap) nwrap++;
      if (done) ndone++;
      checks++;
      if (q !== to_q(eq) || pass_cnt !== ep) begin
        failures++;
        $display("[TB] FAIL basic_seq[%0d] q=%0d pass=%0d exp q=%0d pass=%0d", i, q, pass_cnt, to_q(eq), ep);
      end
      checks++;
      if (wrap !== (i == 5 || i == 10) || done !== (i == 10) || busy !== (i != 10)) begin
        failures++;
        $display("[TB] FAIL basic_flags[%0d] wrap=%b done=%b busy=%b", i, wrap, done, busy);
      end
    end
    checks++;
    if (nwrap != 2 || ndone != 1) begin
      failures++;
      $display("[TB] FAIL basic_counts wraps=%0d dones=%0d exp 2 1", nwrap, ndone);
    end
  endtask

  // Called right after the DONE cycle of the previous run.
  task automatic test_back_to_back();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass_cnt !== 2'd0) begin
      failures++;
      $display("[TB] FAIL b2b_idle busy=%b done=%b pass=%0d exp 0 0 0", busy, done, pass_cnt);
    end
    start_run(3'd1, 2'd0);
    checks++;
    if (busy !== 1'b1 || q !== to_q(3'd0)) begin
      failures++;
      $display("[TB] FAIL b2b_start busy=%b q=%0d exp busy=1 q=0", busy, q);
    end
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || wrap !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_done done=%b wrap=%b exp 1 1", done, wrap);
    end
    tick();
  endtask

  task automatic test_full_range();
    start_run(3'd7, 2'd0);
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) tick();
      checks++;
      if (q !== to_q(3'(i % 8)) || done !== (i == 8) || wrap !== (i == 8)) begin
        failures++;
        $display("[TB] FAIL full_range[%0d] q=%0d done=%b wrap=%b exp q=%0d", i, q, done, wrap, to_q(3'(i % 8)));
      end
    end
    tick();
  endtask

  task automatic test_pause_stop();
    start_run(3'd6, 2'd0);
    tick(); tick();
    checks++;
    if (q !== to_q(3'd2)) begin
      failures++;
      $display("[TB] FAIL pause_pre q=%0d exp %0d", q, to_q(3'd2));
    end
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== to_q(3'd2) || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL pause_hold[%0d] q=%0d busy=%b exp q=%0d busy=1", i, q, busy, to_q(3'd2));
      end
    end
    pause = 1'b0;
    tick();
    checks++;
    if (q !== to_q(3'd2)) begin
      failures++;
      $display("[TB] FAIL pause_resume_edge q=%0d exp %0d", q, to_q(3'd2));
    end
    tick();
    checks++;
    if (q !== to_q(3'd3)) begin
      failures++;
      $display("[TB] FAIL pause_resume_count q=%0d exp %0d", q, to_q(3'd3));
    end
    tick(); tick();
    checks++;
    if (q !== to_q(3'd5)) begin
      failures++;
      $display("[TB] FAIL stop_pre q=%0d exp %0d", q, to_q(3'd5));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (q !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || pass_cnt !== 2'd0) begin
      failures++;
      $display("[TB] FAIL stop_idle q=%0d busy=%b done=%b pass=%0d exp 0 0 0 0", q, busy, done, pass_cnt);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stop_no_done done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_limit_zero();
    start_run(3'd0, 2'd3);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (wrap !== 1'b1 || q !== 3'd0 || pass_cnt !== 2'((i < 4) ? i : 3) || done !== (i == 4)) begin
        failures++;
        $display("[TB] FAIL limit_zero[%0d] wrap=%b q=%0d pass=%0d done=%b", i, wrap, q, pass_cnt, done);
      end
    end
    tick();
    checks++;
    if (wrap !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL limit_zero_end wrap=%b done=%b busy=%b exp 0 0 0", wrap, done, busy);
    end
  endtask

  task automatic test_ignore_start_and_limit();
    start_run(3'd2, 2'd0);
    limit  = 3'd6;
    passes = 2'd3;
    start  = 1'b1;
    tick();
    checks++;
    if (q !== to_q(3'd1) || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ignore_start q=%0d busy=%b exp q=%0d busy=1", q, busy, to_q(3'd1));
    end
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (q !== 3'd0 || done !== 1'b1 || wrap !== 1'b1) begin
      failures++;
      $display("[TB] FAIL latched_limit q=%0d done=%b wrap=%b exp 0 1 1", q, done, wrap);
    end
    tick();
  endtask

  task automatic test_collision();
    start_run(3'd1, 2'd0);
    tick();
    checks++;
    if (q !== to_q(3'd1)) begin
      failures++;
      $display("[TB] FAIL collision_pre q=%0d exp %0d", q, to_q(3'd1));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || q !== 3'd0) begin
      failures++;
      $display("[TB] FAIL collision done=%b busy=%b q=%0d exp 0 0 0", done, busy, q);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL collision_after done=%b exp 0", done);
    end
  endtask

  task automatic test_reset_mid_run();
    start_run(3'd5, 2'd0);
    tick(); tick(); tick();
    checks++;
    if (q !== to_q(3'd3)) begin
      failures++;
      $display("[TB] FAIL midrst_pre q=%0d exp %0d", q, to_q(3'd3));
    end
    #2;
    clr = 1'b1;
    #1;
    checks++;
    if ({q, pass_cnt, busy, wrap, done} !== 8'd0) begin
      failures++;
      $display("[TB] FAIL midrst_async got=%b exp=%b", {q, pass_cnt, busy, wrap, done}, 8'd0);
    end
    tick();
    clr = 1'b0;
    tick();
    start_run(3'd5, 2'd0);
    checks++;
    if (q !== 3'd0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_restart q=%0d busy=%b exp 0 1", q, busy);
    end
    tick();
    checks++;
    if (q !== to_q(3'd1)) begin
      failures++;
      $display("[TB] FAIL midrst_count q=%0d exp %0d", q, to_q(3'd1));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_run();
    test_back_to_back();
    test_full_range();
    test_pause_stop();
    test_limit_zero();
    test_ignore_start_and_limit();
    test_collision();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_seq_ctrl.md
# count_seq_ctrl

Run controller for the 3-bit up-counter datapath. On a start command it runs the counter from 0 up to a programmed limit, repeats that for a programmed number of passes, and then reports completion. It also handles pause and abort requests. It sits between a host/control FSM and any logic that consumes the 3-bit count, and replaces free-running counting with bounded, commanded runs.

## Interface
Parameters:
- `WIDTH`, 3, count width; `limit` and `q` are this wide.
- `PASS_W`, 2, width of pass counter; `passes` and `pass_cnt` are this wide.

Ports:
- `clk`  in  1  clock; all state changes on posedge.
- `clr`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a run; sampled only in IDLE.
- `stop`  in  1  abort run; sampled in RUN and PAUSE.
- `pause`  in  1  level; freezes the count while high in RUN or PAUSE.
- `limit`  in  WIDTH  terminal count; latched on accepted start.
- `passes`  in  PASS_W  extra passes after the first; latched on accepted start.
- `q`  out  WIDTH  current count, registered.
- `pass_cnt`  out  PASS_W  index of the current pass, registered.
- `busy`  out  1  high in RUN or PAUSE.
- `wrap`  out  1  one-cycle pulse on each limit→0 transition.
- `done`  out  1  one-cycle pulse after the final pass.

## Operation
- Reset (`clr`=1, any time): state=IDLE; `q`=0, `pass_cnt`=0, `busy`=0, `wrap`=0, `done`=0; latched `limit`/`passes` cleared to 0. Reset takes effect immediately, including mid-run.
- States:
  - IDLE: `q` and `pass_cnt` held at 0. `start`=1 → latch `limit_r`, `passes_r`; next state RUN.
  - RUN: priority is `stop` > `pause` > count.
    - `stop` → IDLE; `q`, `pass_cnt` ← 0; no `done`.
    - `pause` → PAUSE; `q` and `pass_cnt` held.
    - Otherwise, if `q`≠`limit_r`: `q`←`q`+1.
    - Otherwise (`q`=`limit_r`): `q`←0 and `wrap`←1. If `pass_cnt`=`passes_r`, next state DONE; else `pass_cnt`+1.
  - PAUSE: `stop` → IDLE (as above). `pause`=0 → RUN, with no count on that edge. Otherwise hold.
  - DONE: `done`=1 for exactly this cycle; `q`=0; `pass_cnt` keeps its final value. Next state IDLE, where `pass_cnt` clears to 0.
- `start` outside IDLE is ignored; it is not queued. Changes to `limit`/`passes` after an accepted start have no effect until the next accepted start.
- Arithmetic: `q` is modulo 2^WIDTH, but never exceeds `limit_r`. `limit_r`=0 means a wrap every RUN cycle. `limit_r`=7 gives the full 0..7 sequence.
- `busy` = (state==RUN || state==PAUSE), registered with the state.

## Timing
- Start latency: `start` sampled at edge k → `busy`=1 and `q`=0 after edge k. The first increment happens at edge k+1.
- Uninterrupted run length: (`limit_r`+1)×(`passes_r`+1) RUN cycles. `done` is high in the single cycle after the final wrap edge.
- `wrap` is high in the cycle following the edge that took `q` from `limit_r` to 0. It is also asserted on the final wrap, in the same cycle as `done`.
- Earliest restart: back-to-back `start` is accepted on the edge after DONE→IDLE. The minimum gap between runs is 2 cycles (DONE, then IDLE).
- Pause: `pause` high at edge e means `q` is frozen from edge e onward. Counting resumes on the second edge after `pause` falls.
- `stop` and the final wrap on the same edge: `stop` wins; `done` is not asserted.

## Configuration
- `COUNT_SEQ_GRAY_EN`:
  - Defined: `q` outputs the Gray code of the internal binary count (bin ^ (bin>>1)), registered, with no added latency. Limit comparison and wrap still use the binary count; `limit` stays binary.
  - Undefined: `q` outputs the binary count.

## Test plan
- Reset mid-run: start `limit`=5, `passes`=0, assert `clr` asynchronously at `q`=3 → all outputs 0 immediately, state IDLE; deassert, then `start` → `q` restarts from 0.
- Basic run: `limit`=4, `passes`=1, `start` pulse → `q` sequence 0,1,2,3,4,0,1,2,3,4,0; `wrap` pulses twice; `done` pulses once, 10 RUN cycles after start.
- Full range with Gray: `limit`=7, `passes`=0, with `COUNT_SEQ_GRAY_EN` defined → `q` = 0,1,3,2,6,7,5,4,0; `done` once.
- Pause/stop: `limit`=6, pause at `q`=2 for 3 cycles → `q` holds 2, then 3 on the second edge after release; later `stop` at `q`=5 → IDLE, `q`=0, no `done`.
- Edge cases: `limit`=0, `passes`=3 → `wrap` on 4 consecutive cycles, then `done`. `start` during RUN is ignored. Changing `limit` mid-run does not alter the terminal count.
- Collision: `stop` asserted on the final-wrap edge → IDLE, `done` stays 0.
